// File: rtl/fifo_write_serializer_pkg.sv
// Shared types for the FIFO write serializer.
// Imported by the serializer top.
package fifo_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int beat_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_serializer_if.sv
// Input vector valid/ready handshake.
// master = upstream producer, slave = serializer.
interface fifo_write_serializer_if #(
  parameter int DSIZE  = 8,
  parameter int NBEATS = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [NBEATS*DSIZE-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/fifo_write_serializer.sv
// Splits one wide vector into NBEATS FIFO words
// and drives the FIFO write port honouring wfull.
module fifo_write_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int NBEATS = 4,
  parameter int CNTW   = 16
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_write_serializer_if.slave in_if,
  input  logic                sync_clr,
  input  logic                wfull,
  output logic                winc,
  output logic [DSIZE-1:0]    wdata,
  output logic                busy,
  output logic [CNTW-1:0]     vec_cnt
);

  localparam int BW = beat_w(NBEATS);
  localparam int VW = NBEATS * DSIZE;
  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);

  ser_state_t      state_q;
  ser_state_t      state_d;
  logic [VW-1:0]   hold_q;
  logic [VW-1:0]   hold_d;
  logic [BW-1:0]   beat_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            beat_clr;
  logic            beat_inc;
  logic            load;
  logic            last;
  logic            take;

  assign last    = (beat_q == LAST);
  assign take    = winc && !wfull;
  assign vec_cnt = cnt_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // A single-beat vector has no beat index to track.
  if (NBEATS > 1) begin : g_beat
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
        beat_q <= '0;
      end else if (beat_clr) begin
        beat_q <= '0;
      end else if (beat_inc) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end else begin : g_beat1
    assign beat_q = '0;
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    cnt_d          = cnt_q;
    beat_clr       = 1'b0;
    beat_inc       = 1'b0;
    load           = 1'b0;
    winc           = 1'b0;
    busy           = 1'b0;
    wdata          = '0;
    in_if.in_ready = 1'b0;

    unique case (1'b1)
      (state_q == IDLE): begin
        in_if.in_ready = !sync_clr;
      end
      (state_q == SEND): begin
        winc  = 1'b1;
        busy  = 1'b1;
        wdata = hold_q[beat_q*DSIZE +: DSIZE];
        // ready only when the last beat leaves now
        in_if.in_ready = last && !wfull && !sync_clr;
      end
      default: ;
    endcase

    if (sync_clr) begin
      state_d  = IDLE;
      beat_clr = 1'b1;
    end else if (state_q == IDLE) begin
      load = in_if.in_valid;
    end else if (take) begin
      if (last) begin
        cnt_d   = cnt_q + 1'b1;
        load    = in_if.in_valid;
        state_d = IDLE;
      end else begin
        beat_inc = 1'b1;
      end
    end

    if (load) begin
      hold_d   = in_if.in_data;
      state_d  = SEND;
      beat_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_serializer.sv
// Directed bench for fifo_write_serializer:
// vector table plus reset, wrap and FIFO-full sequences.
module tb_fifo_write_serializer;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        sync_clr;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic [15:0] vec_cnt;

  logic        sync_clr2;
  logic        wfull2;
  logic        winc2;
  logic [7:0]  wdata2;
  logic        busy2;
  logic [1:0]  vec_cnt2;

  logic        model_en = 1'b0;
  logic        mfull    = 1'b0;
  int          mcnt     = 0;
  logic [7:0]  mem [16];

  int pass_cnt = 0;
  int total    = 0;

  fifo_write_serializer_if #(.DSIZE(8), .NBEATS(4)) bus ();
  fifo_write_serializer_if #(.DSIZE(8), .NBEATS(4)) bus2 ();

  fifo_write_serializer #(.DSIZE(8), .NBEATS(4), .CNTW(16)) u_dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .in_if    (bus),
    .sync_clr (sync_clr),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .vec_cnt  (vec_cnt)
  );

  fifo_write_serializer #(.DSIZE(8), .NBEATS(4), .CNTW(2)) u_dut2 (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .in_if    (bus2),
    .sync_clr (sync_clr2),
    .wfull    (wfull2),
    .winc     (winc2),
    .wdata    (wdata2),
    .busy     (busy2),
    .vec_cnt  (vec_cnt2)
  );

  always #5 wclk = ~wclk;

  // 16-deep FIFO write side with a stalled reader
  assign wfull2 = model_en && mfull;

  always @(posedge wclk) begin
    if (model_en && winc2 && !wfull2 && mcnt < 16) begin
      mem[mcnt] <= wdata2;
      mcnt      <= mcnt + 1;
      mfull     <= (mcnt + 1 >= 16);
    end
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        f;
    logic        c;
    logic        w;
    logic [7:0]  wd;
    logic        b;
    logic        r;
    logic [15:0] n;
  } row_t;

  row_t tbl[$];

  task automatic add(
    input logic v, input logic [31:0] d,
    input logic f, input logic c,
    input logic w, input logic [7:0] wd,
    input logic b, input logic r,
    input logic [15:0] n
  );
    row_t x;
    x = '{v, d, f, c, w, wd, b, r, n};
    tbl.push_back(x);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n         = 1'b0;
    sync_clr       = 1'b0;
    wfull          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    sync_clr2      = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;

    // v  data          f  c   w  wd     b  r  n
    add(1, 32'hDDCCBBAA, 0, 0,  0, 8'h00, 0, 1, 0);
    add(0, 32'h0,        0, 0,  1, 8'hAA, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hBB, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hCC, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'hDD, 1, 1, 0);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 1);
    add(1, 32'hDDCCBBAA, 0, 0,  0, 8'h00, 0, 1, 1);
    add(0, 32'h0,        0, 0,  1, 8'hAA, 1, 0, 1);
    add(0, 32'h0,        1, 0,  1, 8'hBB, 1, 0, 1);
    add(0, 32'h0,        1, 0,  1, 8'hBB, 1, 0, 1);
    add(0, 32'h0,        1, 0,  1, 8'hBB, 1, 0, 1);
    add(0, 32'h0,        0, 0,  1, 8'hBB, 1, 0, 1);
    add(0, 32'h0,        0, 0,  1, 8'hCC, 1, 0, 1);
    add(0, 32'h0,        0, 0,  1, 8'hDD, 1, 1, 1);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 2);
    add(1, 32'h04030201, 0, 0,  0, 8'h00, 0, 1, 2);
    add(1, 32'h08070605, 0, 0,  1, 8'h01, 1, 0, 2);
    add(1, 32'h08070605, 0, 0,  1, 8'h02, 1, 0, 2);
    add(1, 32'h08070605, 0, 0,  1, 8'h03, 1, 0, 2);
    add(1, 32'h08070605, 0, 0,  1, 8'h04, 1, 1, 2);
    add(0, 32'h0,        0, 0,  1, 8'h05, 1, 0, 3);
    add(0, 32'h0,        0, 0,  1, 8'h06, 1, 0, 3);
    add(0, 32'h0,        0, 0,  1, 8'h07, 1, 0, 3);
    add(0, 32'h0,        0, 0,  1, 8'h08, 1, 1, 3);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 4);
    add(1, 32'h44332211, 0, 0,  0, 8'h00, 0, 1, 4);
    add(0, 32'h0,        0, 0,  1, 8'h11, 1, 0, 4);
    add(0, 32'h0,        0, 0,  1, 8'h22, 1, 0, 4);
    add(0, 32'h0,        0, 1,  1, 8'h33, 1, 0, 4);
    add(1, 32'hAABBCCDD, 0, 0,  0, 8'h00, 0, 1, 4);
    add(0, 32'h0,        0, 0,  1, 8'hDD, 1, 0, 4);
    add(0, 32'h0,        0, 0,  1, 8'hCC, 1, 0, 4);
    add(0, 32'h0,        0, 0,  1, 8'hBB, 1, 0, 4);
    add(0, 32'h0,        0, 0,  1, 8'hAA, 1, 1, 4);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 5);
    add(1, 32'h12345678, 0, 1,  0, 8'h00, 0, 0, 5);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 5);
    add(1, 32'h0D0C0B0A, 0, 0,  0, 8'h00, 0, 1, 5);
    add(0, 32'h0,        0, 0,  1, 8'h0A, 1, 0, 5);
    add(0, 32'h0,        0, 0,  1, 8'h0B, 1, 0, 5);
    add(0, 32'h0,        0, 0,  1, 8'h0C, 1, 0, 5);
    add(0, 32'h0,        1, 0,  1, 8'h0D, 1, 0, 5);
    add(0, 32'h0,        0, 0,  1, 8'h0D, 1, 1, 5);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 6);
    add(1, 32'h55667788, 0, 0,  0, 8'h00, 0, 1, 6);
    add(0, 32'h0,        0, 0,  1, 8'h88, 1, 0, 6);
    add(0, 32'h0,        0, 0,  1, 8'h77, 1, 0, 6);
    add(0, 32'h0,        0, 0,  1, 8'h66, 1, 0, 6);
    add(1, 32'h99999999, 0, 1,  1, 8'h55, 1, 0, 6);
    add(0, 32'h0,        0, 0,  0, 8'h00, 0, 1, 6);

    repeat (2) @(posedge wclk);
    @(negedge wclk);
    chk("rst_winc",  winc,         0);
    chk("rst_wdata", wdata,        0);
    chk("rst_busy",  busy,         0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_cnt",   vec_cnt,      0);
    wrst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      wfull        = tbl[i].f;
      sync_clr     = tbl[i].c;
      @(negedge wclk);
      chk($sformatf("r%0d_winc", i),  winc,         tbl[i].w);
      chk($sformatf("r%0d_wdata", i), wdata,        tbl[i].wd);
      chk($sformatf("r%0d_busy", i),  busy,         tbl[i].b);
      chk($sformatf("r%0d_ready", i), bus.in_ready, tbl[i].r);
      chk($sformatf("r%0d_cnt", i),   vec_cnt,      tbl[i].n);
      tick();
    end
    bus.in_valid = 1'b0;
    sync_clr     = 1'b0;
    wfull        = 1'b0;

    // asynchronous reset in the middle of a vector
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h87654321;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("ar_pre_wdata", wdata, 8'h43);
    wrst_n = 1'b0;
    #1;
    chk("ar_winc",  winc,         0);
    chk("ar_wdata", wdata,        0);
    chk("ar_busy",  busy,         0);
    chk("ar_cnt",   vec_cnt,      0);
    chk("ar_ready", bus.in_ready, 1);
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] dv;
      dv = 32'h87654321;
      @(negedge wclk);
      chk($sformatf("ar_b%0d", k), wdata, dv[k*8 +: 8]);
      chk($sformatf("ar_w%0d", k), winc,  1);
      tick();
    end
    @(negedge wclk);
    chk("ar_done_cnt", vec_cnt, 1);
    chk("ar_done_busy", busy,   0);
    tick();

    // narrow counter wraps
    bus2.in_data = 32'h44332211;
    for (int v = 0; v < 5; v++) begin
      bus2.in_valid = 1'b1;
      tick();
      bus2.in_valid = 1'b0;
      repeat (4) tick();
      @(negedge wclk);
      chk($sformatf("wrap_v%0d", v), vec_cnt2, (v + 1) % 4);
      tick();
    end

    // 16-deep FIFO, reader stalled, 20 beats offered
    model_en      = 1'b1;
    bus2.in_valid = 1'b1;
    repeat (40) tick();
    @(negedge wclk);
    chk("ff_written", mcnt,          16);
    chk("ff_wfull",   wfull2,        1);
    chk("ff_winc",    winc2,         1);
    chk("ff_busy",    busy2,         1);
    chk("ff_ready",   bus2.in_ready, 0);
    chk("ff_wdata",   wdata2,        8'h11);
    chk("ff_cnt",     vec_cnt2,      1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("ff_mem%0d", k), mem[k], 8'h11 * ((k % 4) + 1));
    bus2.in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
